lfsr_scramble_stream: RTL and testbench
=======================================

# lfsr_scramble_stream

Streaming LFSR scrambler/descrambler with valid/ready flow control on both sides, selectable multiplicative (self-synchronising) or additive operation, per-beat bypass, and runtime seed loading. It sits between a framing/encoding stage and a SERDES or PCS datapath, for example 64b66b or 128b130b. It instantiates the existing `lfsr` combinational next-state core for the per-beat computation, and adds buffering, handshakes and state control around it.

## Interface
- LFSR_WIDTH, 58, LFSR register width
- LFSR_POLY, 58'h8000000001, polynomial with the top term suppressed
- LFSR_INIT, {LFSR_WIDTH{1'b1}}, state after reset
- LFSR_CONFIG, "FIBONACCI", "FIBONACCI" or "GALOIS"; passed to `lfsr`
- REVERSE, 1, bit-reverse input and output (LSB first on the line)
- DATA_WIDTH, 64, data bus width; one LFSR shift per bit
- MODE, "SCRAMBLE", one of the following:
  - "SCRAMBLE": multiplicative; `lfsr` with LFSR_FEED_FORWARD=0
  - "DESCRAMBLE": multiplicative; `lfsr` with LFSR_FEED_FORWARD=1
  - "ADDITIVE": keystream XOR; the same logic serves both directions
- STYLE, "AUTO", passed to `lfsr`
- clk  input  1  clock; all logic on the rising edge
- rst  input  1  reset, synchronous, active-high
- s_data  input  DATA_WIDTH  input beat
- s_bypass  input  1  per-beat sideband: pass the beat unmodified
- s_valid  input  1  input beat valid
- s_ready  output  1  input can accept a beat
- m_data  output  DATA_WIDTH  processed beat
- m_valid  output  1  output beat valid
- m_ready  input  1  downstream accepts a beat
- seed_data  input  LFSR_WIDTH  new LFSR state
- seed_load  input  1  one-cycle strobe to load seed_data
- beat_count  output  32  number of non-bypass beats processed; wraps

## Operation
- A beat is accepted on a cycle with s_valid && s_ready. It is processed with the current state_reg and the result is written to the output stage in the same cycle.
- SCRAMBLE and DESCRAMBLE:
  - data goes into `lfsr` data_in
  - m_data = lfsr data_out
  - state_reg ← lfsr state_out
- ADDITIVE:
  - `lfsr` data_in is tied to 0
  - m_data = s_data XOR lfsr data_out
  - state_reg ← lfsr state_out
- In DESCRAMBLE mode with DATA_WIDTH ≥ LFSR_WIDTH, output self-synchronises after one received beat, whatever the state.
- Bypass beat (s_bypass=1):
  - m_data = s_data
  - state_reg unchanged
  - beat_count unchanged
- Output stage is a 2-entry buffer: an output register plus a skid register. Order is preserved and no beat is dropped or duplicated.
- s_ready = skid register empty. It is registered, so there is no combinational path from m_ready to s_ready.
- m_valid is held high and m_data is held stable until m_ready is high.
- beat_count increments by 1 per accepted non-bypass beat and wraps from 32'hFFFFFFFF to 0.
- seed_load:
  - state_reg ← seed_data at the next edge
  - a beat accepted in the same cycle is processed with the old state, and seed_data still wins the state update
  - buffered beats are not altered
  - beat_count unaffected
- Reset (mid-stream included):
  - state_reg ← LFSR_INIT
  - both buffer entries are discarded
  - beat_count ← 0
  - any beat that was in flight is lost

## Timing
- Latency: accept edge N gives m_valid=1 after edge N, from the output register. Input-to-output latency is 1 cycle.
- Throughput: 1 beat/cycle while m_ready=1.
- With m_ready low:
  - 1 beat fills the output register and s_ready stays 1
  - a 2nd beat fills the skid register and s_ready drops 0 after that edge
- Skid drain: first cycle with m_ready=1 transfers the output entry, then the skid entry moves to the output register and s_ready returns 1 after that edge.
- Reset values:
  - m_valid 0, m_data 0, s_ready 0, beat_count 0
  - s_ready goes 1 on the first cycle after rst deasserts
- rst has priority over seed_load, s_valid and m_ready.

## Test plan
- SCRAMBLE round trip:
  - setup: MODE=SCRAMBLE with DATA_WIDTH=64 feeding MODE=DESCRAMBLE, both with LFSR_INIT all-ones
  - stimulus: 1000 random beats, m_ready random at 50%
  - required: descrambled output equals input exactly, in order
  - required: beat_count = 1000 on both blocks
- Self-sync:
  - setup: descrambler LFSR_INIT=58'h0, scrambler all-ones
  - required: first descrambled beat may mismatch; beats 2..N equal the source
- Backpressure:
  - stimulus: s_valid=1 continuously, m_ready=0 for cycles 3-5
  - required: s_ready=0 after the 2nd stalled accept
  - required: no loss or duplication
  - required: m_data is held stable while stalled
  - required: order is preserved when m_ready returns
- Seed and additive:
  - setup: MODE=ADDITIVE, LFSR 7-bit 7'h41, DATA_WIDTH=8
  - stimulus: seed_load with 7'h01 in the same cycle as a beat, then further all-zero beats
  - required: that beat uses the old state
  - required: subsequent outputs match a bit-serial PRBS7 model seeded with 7'h01
- Bypass:
  - stimulus: beats A, B(bypass, 64'hDEADBEEF_00000000), C
  - required: B is output unchanged
  - required: C's output equals the output for A→C with B absent
  - required: beat_count = 2
- Reset mid-stream:
  - stimulus: rst for 1 cycle with both buffer entries full
  - required: next cycle m_valid=0, s_ready=0, beat_count=0
  - required: after rst, state restarts from LFSR_INIT and the first beat matches the reset-fresh model

Source files
------------

// File: rtl/lfsr_scramble_stream.sv
// Streaming LFSR scrambler/descrambler (multiplicative or additive) with a 2-entry output buffer.
// Also holds the combinational lfsr next-state core that the stream wrapper instantiates.

module lfsr #(
    parameter int                    LFSR_WIDTH        = 58,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY         = 58'h8000000001,
    parameter string                 LFSR_CONFIG       = "FIBONACCI",
    parameter bit                    LFSR_FEED_FORWARD = 1'b0,
    parameter bit                    REVERSE           = 1'b1,
    parameter int                    DATA_WIDTH        = 64,
    parameter string                 STYLE             = "AUTO"
) (
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [LFSR_WIDTH-1:0] state_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [LFSR_WIDTH-1:0] state_out
);

    // One shift per data bit; REVERSE puts data bit 0 first on the line.
    always_comb begin
        logic [LFSR_WIDTH-1:0] s;
        logic                  d;
        logic                  fb;
        logic                  o;
        s        = state_in;
        data_out = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            d = REVERSE ? data_in[i] : data_in[DATA_WIDTH-1-i];
            if (LFSR_CONFIG == "GALOIS") begin
                o  = s[LFSR_WIDTH-1] ^ d;
                fb = LFSR_FEED_FORWARD ? d : o;
                s  = {s[LFSR_WIDTH-2:0], fb} ^ (fb ? {LFSR_POLY[LFSR_WIDTH-1:1], 1'b0} : '0);
            end else begin
                if (STYLE == "LOOP") begin
                    fb = s[LFSR_WIDTH-1];
                    for (int j = 1; j < LFSR_WIDTH; j++) begin
                        if (LFSR_POLY[j]) fb = fb ^ s[j-1];
                    end
                end else begin
                    fb = s[LFSR_WIDTH-1] ^ (^(s[LFSR_WIDTH-2:0] & LFSR_POLY[LFSR_WIDTH-1:1]));
                end
                o = fb ^ d;
                // Feed-forward shifts in the received bit, which is what makes descrambling self-synchronise.
                s = {s[LFSR_WIDTH-2:0], (LFSR_FEED_FORWARD ? d : o)};
            end
            if (REVERSE) data_out[i] = o;
            else         data_out[DATA_WIDTH-1-i] = o;
        end
        state_out = s;
    end

endmodule

module lfsr_scramble_stream #(
    parameter int                    LFSR_WIDTH  = 58,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY   = 58'h8000000001,
    parameter logic [LFSR_WIDTH-1:0] LFSR_INIT   = {LFSR_WIDTH{1'b1}},
    parameter string                 LFSR_CONFIG = "FIBONACCI",
    parameter bit                    REVERSE     = 1'b1,
    parameter int                    DATA_WIDTH  = 64,
    parameter string                 MODE        = "SCRAMBLE",
    parameter string                 STYLE       = "AUTO"
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_bypass,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    input  logic [LFSR_WIDTH-1:0] seed_data,
    input  logic                  seed_load,
    output logic [31:0]           beat_count
);

    localparam bit IS_ADDITIVE = (MODE == "ADDITIVE");

    logic [LFSR_WIDTH-1:0] state_q, state_d;
    logic [31:0]           beat_count_q, beat_count_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
    logic                  s_ready_q, s_ready_d;

    logic                  accept;
    logic                  advance;
    logic [DATA_WIDTH-1:0] core_in;
    logic [DATA_WIDTH-1:0] core_out;
    logic [LFSR_WIDTH-1:0] core_state;
    logic [DATA_WIDTH-1:0] proc_data;

    lfsr #(
        .LFSR_WIDTH       (LFSR_WIDTH),
        .LFSR_POLY        (LFSR_POLY),
        .LFSR_CONFIG      (LFSR_CONFIG),
        .LFSR_FEED_FORWARD(MODE == "DESCRAMBLE"),
        .REVERSE          (REVERSE),
        .DATA_WIDTH       (DATA_WIDTH),
        .STYLE            (STYLE)
    ) u_lfsr (
        .data_in  (core_in),
        .state_in (state_q),
        .data_out (core_out),
        .state_out(core_state)
    );

    // Handshake: a beat moves on any edge where valid && ready are both high; valid never
    // waits on ready, and once valid is high the beat stays put until it is taken.
    assign core_in   = IS_ADDITIVE ? '0 : s_data;
    assign proc_data = s_bypass ? s_data : (IS_ADDITIVE ? (s_data ^ core_out) : core_out);
    assign accept    = s_valid && s_ready_q;
    assign advance   = accept && !s_bypass;

    always_comb begin
        state_d      = state_q;
        beat_count_d = beat_count_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (advance) begin
            state_d      = core_state;
            beat_count_d = beat_count_q + 32'd1;
        end
        // The beat accepted this cycle already used the old state; the seed still wins.
        if (seed_load) state_d = seed_data;

        if (out_valid_q && m_ready) begin
            if (skid_valid_q) begin
                out_data_d   = skid_data_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d = 1'b0;
            end
        end
        if (accept) begin
            if (!out_valid_d) begin
                out_valid_d = 1'b1;
                out_data_d  = proc_data;
            end else begin
                skid_valid_d = 1'b1;
                skid_data_d  = proc_data;
            end
        end

        s_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= LFSR_INIT;
            beat_count_q <= '0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            s_ready_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_count_q <= beat_count_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            s_ready_q    <= s_ready_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign m_valid    = out_valid_q;
    assign m_data     = out_data_q;
    assign beat_count = beat_count_q;

endmodule

// File: tb/tb_lfsr_scramble_stream.sv
// Bench for lfsr_scramble_stream: round trip, self-sync, backpressure, reset, bypass, seed, additive PRBS7.
module tb_lfsr_scramble_stream;

    localparam int M_RT = 0, M_SS = 1, M_DIR = 2, M_ADD = 3;
    localparam int K_SCR = 0, K_DSC = 1, K_ADD = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic dir_rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- DUT signals ----------------
    logic [63:0] scr_s_data, scr_m_data, dsc_m_data;
    logic        scr_s_valid, scr_s_ready, scr_m_valid;
    logic        dsc_s_ready, dsc_m_valid, dsc_m_ready;
    logic [31:0] scr_beat_count, dsc_beat_count;

    logic [63:0] ss_s_data, ss_m_data;
    logic        ss_s_valid, ss_s_ready, ss_m_valid, ss_m_ready;
    logic [31:0] ss_beat_count;

    logic [63:0] dir_s_data, dir_m_data;
    logic        dir_s_bypass, dir_s_valid, dir_s_ready, dir_m_valid, dir_m_ready;
    logic [57:0] dir_seed_data;
    logic        dir_seed_load;
    logic [31:0] dir_beat_count;

    logic [7:0]  add_s_data, add_m_data;
    logic        add_s_valid, add_s_ready, add_m_valid, add_m_ready;
    logic [6:0]  add_seed_data;
    logic        add_seed_load;
    logic [31:0] add_beat_count;

    lfsr_scramble_stream #(.MODE("SCRAMBLE")) u_scr (
        .clk(clk), .rst(rst), .s_data(scr_s_data), .s_bypass(1'b0), .s_valid(scr_s_valid),
        .s_ready(scr_s_ready), .m_data(scr_m_data), .m_valid(scr_m_valid), .m_ready(dsc_s_ready),
        .seed_data(58'h0), .seed_load(1'b0), .beat_count(scr_beat_count));

    lfsr_scramble_stream #(.MODE("DESCRAMBLE")) u_dsc (
        .clk(clk), .rst(rst), .s_data(scr_m_data), .s_bypass(1'b0), .s_valid(scr_m_valid),
        .s_ready(dsc_s_ready), .m_data(dsc_m_data), .m_valid(dsc_m_valid), .m_ready(dsc_m_ready),
        .seed_data(58'h0), .seed_load(1'b0), .beat_count(dsc_beat_count));

    lfsr_scramble_stream #(.MODE("DESCRAMBLE"), .LFSR_INIT(58'h0)) u_ss (
        .clk(clk), .rst(rst), .s_data(ss_s_data), .s_bypass(1'b0), .s_valid(ss_s_valid),
        .s_ready(ss_s_ready), .m_data(ss_m_data), .m_valid(ss_m_valid), .m_ready(ss_m_ready),
        .seed_data(58'h0), .seed_load(1'b0), .beat_count(ss_beat_count));

    lfsr_scramble_stream #(.MODE("SCRAMBLE")) u_dir (
        .clk(clk), .rst(dir_rst), .s_data(dir_s_data), .s_bypass(dir_s_bypass), .s_valid(dir_s_valid),
        .s_ready(dir_s_ready), .m_data(dir_m_data), .m_valid(dir_m_valid), .m_ready(dir_m_ready),
        .seed_data(dir_seed_data), .seed_load(dir_seed_load), .beat_count(dir_beat_count));

    lfsr_scramble_stream #(.MODE("ADDITIVE"), .LFSR_WIDTH(7), .LFSR_POLY(7'h41), .DATA_WIDTH(8)) u_add (
        .clk(clk), .rst(rst), .s_data(add_s_data), .s_bypass(1'b0), .s_valid(add_s_valid),
        .s_ready(add_s_ready), .m_data(add_m_data), .m_valid(add_m_valid), .m_ready(add_m_ready),
        .seed_data(add_seed_data), .seed_load(add_seed_load), .beat_count(add_beat_count));

    // ---------------- reference model ----------------
    // Line-bit recurrence: each line bit y[n] combines with y[n-t] for every tap distance t
    // (t = register width, plus each set polynomial bit above bit 0). hist[m][k] holds y[n-1-k];
    // line order is data bit 0 first.
    logic [63:0] hist [4];

    task automatic model_beat(input int m, input int kind, input logic [63:0] din,
                              output logic [63:0] dout);
        int          lw;
        int          dw;
        logic [63:0] poly;
        logic        k;
        logic        x;
        logic        keep;
        lw   = (m == M_ADD) ? 7 : 58;
        dw   = (m == M_ADD) ? 8 : 64;
        poly = (m == M_ADD) ? 64'h41 : 64'h8000000001;
        dout = '0;
        for (int i = 0; i < dw; i++) begin
            k = hist[m][lw-1];
            for (int t = 1; t < lw; t++) begin
                if (poly[t]) k = k ^ hist[m][t-1];
            end
            x       = din[i];
            dout[i] = x ^ k;
            case (kind)
                K_SCR:   keep = x ^ k;
                K_DSC:   keep = x;
                default: keep = k;
            endcase
            hist[m] = {hist[m][62:0], keep};
        end
    endtask

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard for u_dir ----------------
    logic [63:0] dir_exp_q[$];
    int          dir_cnt;

    // Checks the outputs visible this cycle, drives one cycle of inputs, and advances the model.
    task automatic dir_cycle(input logic v, input logic [63:0] d, input logic byp, input logic mr,
                             input logic sl, input logic [57:0] sd);
        logic [63:0] y;
        int          occ;
        occ = dir_exp_q.size();
        check_eq("dir_s_ready", 64'(dir_s_ready), 64'(occ < 2));
        check_eq("dir_m_valid", 64'(dir_m_valid), 64'(occ > 0));
        if (occ > 0) check_eq("dir_m_data", dir_m_data, dir_exp_q[0]);
        check_eq("dir_beat_count", 64'(dir_beat_count), 64'(dir_cnt));
        dir_s_valid   = v;
        dir_s_data    = d;
        dir_s_bypass  = byp;
        dir_m_ready   = mr;
        dir_seed_load = sl;
        dir_seed_data = sd;
        if (occ > 0 && mr) void'(dir_exp_q.pop_front());
        if (v && occ < 2) begin
            if (byp) y = d;
            else begin
                model_beat(M_DIR, K_SCR, d, y);
                dir_cnt++;
            end
            dir_exp_q.push_back(y);
        end
        if (sl) hist[M_DIR] = {6'b0, sd};
        tick();
    endtask

    task automatic dir_drain();
        for (int i = 0; i < 3; i++) dir_cycle(1'b0, 64'h0, 1'b0, 1'b1, 1'b0, 58'h0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] src_q[$];
        logic [63:0] scr_exp_q[$];
        logic [63:0] ss_q[$];
        logic [7:0]  add_q[$];
        logic [63:0] x;
        logic [63:0] y;
        int          sent;
        int          got;
        int          extra;
        int          cyc;

        rst = 1'b1; dir_rst = 1'b1;
        scr_s_valid = 0; scr_s_data = '0; dsc_m_ready = 0;
        ss_s_valid = 0; ss_s_data = '0; ss_m_ready = 0;
        dir_s_valid = 0; dir_s_data = '0; dir_s_bypass = 0; dir_m_ready = 0;
        dir_seed_load = 0; dir_seed_data = '0;
        add_s_valid = 0; add_s_data = '0; add_m_ready = 0; add_seed_load = 0; add_seed_data = '0;
        for (int m = 0; m < 4; m++) hist[m] = '1;
        dir_cnt = 0;
        repeat (2) tick();

        check_eq("rst_m_valid", 64'(dir_m_valid), 64'd0);
        check_eq("rst_m_data", dir_m_data, 64'd0);
        check_eq("rst_s_ready", 64'(dir_s_ready), 64'd0);
        check_eq("rst_beat_count", 64'(dir_beat_count), 64'd0);
        rst = 1'b0; dir_rst = 1'b0;
        tick();
        check_eq("post_rst_s_ready", 64'(dir_s_ready), 64'd1);
        check_eq("post_rst_add_s_ready", 64'(add_s_ready), 64'd1);

        // Round trip: scrambler feeding descrambler, random valid and 50% downstream ready.
        sent = 0; got = 0; extra = 0; cyc = 0;
        while (got < 1000 && cyc < 20000) begin
            scr_s_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            scr_s_data  = {$urandom, $urandom};
            dsc_m_ready = 1'($urandom_range(0, 1));
            if (scr_s_valid && scr_s_ready) begin
                model_beat(M_RT, K_SCR, scr_s_data, y);
                src_q.push_back(scr_s_data);
                scr_exp_q.push_back(y);
                sent++;
            end
            if (scr_m_valid && dsc_s_ready) begin
                if (scr_exp_q.size() > 0) check_eq("rt_scr_data", scr_m_data, scr_exp_q.pop_front());
                else extra++;
            end
            if (dsc_m_valid && dsc_m_ready) begin
                if (src_q.size() > 0) check_eq("rt_dsc_data", dsc_m_data, src_q.pop_front());
                else extra++;
                got++;
            end
            tick();
            cyc++;
        end
        scr_s_valid = 0; dsc_m_ready = 1;
        repeat (4) tick();
        check_eq("rt_beats", 64'(got), 64'd1000);
        check_eq("rt_extra", 64'(extra), 64'd0);
        check_eq("rt_dsc_idle", 64'(dsc_m_valid), 64'd0);
        check_eq("rt_scr_count", 64'(scr_beat_count), 64'd1000);
        check_eq("rt_dsc_count", 64'(dsc_beat_count), 64'd1000);

        // Self-sync: descrambler starts from zero state, source scrambler from all-ones.
        ss_m_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                x = {$urandom, $urandom};
                model_beat(M_SS, K_SCR, x, y);
                ss_s_valid = 1'b1;
                ss_s_data  = y;
                ss_q.push_back(x);
            end else begin
                ss_s_valid = 1'b0;
            end
            if (i > 0) begin
                check_eq("ss_m_valid", 64'(ss_m_valid), 64'd1);
                x = ss_q.pop_front();
                if (i > 1) check_eq("ss_data", ss_m_data, x);
            end
            tick();
        end
        check_eq("ss_count", 64'(ss_beat_count), 64'd8);

        // Backpressure: continuous valid, m_ready low on cycles 3-5.
        for (int c = 1; c <= 10; c++) begin
            dir_cycle(1'b1, {$urandom, $urandom}, 1'b0, !(c >= 3 && c <= 5), 1'b0, 58'h0);
        end
        dir_drain();

        // Reset mid-stream with both buffer entries full.
        dir_cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 58'h0);
        dir_cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0, 58'h0);
        check_eq("full_s_ready", 64'(dir_s_ready), 64'd0);
        dir_rst = 1'b1; dir_s_valid = 1'b1; dir_m_ready = 1'b1;
        dir_seed_load = 1'b1; dir_seed_data = 58'h123;
        tick();
        check_eq("midrst_m_valid", 64'(dir_m_valid), 64'd0);
        check_eq("midrst_s_ready", 64'(dir_s_ready), 64'd0);
        check_eq("midrst_beat_count", 64'(dir_beat_count), 64'd0);
        dir_rst = 1'b0; dir_s_valid = 1'b0; dir_seed_load = 1'b0;
        dir_exp_q.delete();
        hist[M_DIR] = '1;
        dir_cnt = 0;
        tick();
        dir_cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 58'h0);
        dir_drain();

        // Bypass: A, B (bypass), C after a fresh reset.
        dir_rst = 1'b1;
        tick();
        dir_rst = 1'b0;
        dir_exp_q.delete();
        hist[M_DIR] = '1;
        dir_cnt = 0;
        tick();
        dir_cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 58'h0);
        dir_cycle(1'b1, 64'hDEADBEEF_00000000, 1'b1, 1'b1, 1'b0, 58'h0);
        dir_cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b0, 58'h0);
        dir_drain();
        check_eq("byp_beat_count", 64'(dir_beat_count), 64'd2);

        // Seed load coinciding with an accepted beat, then more beats under stall and flow.
        dir_cycle(1'b1, {$urandom, $urandom}, 1'b0, 1'b1, 1'b1, {26'($urandom), $urandom});
        for (int c = 0; c < 6; c++) begin
            dir_cycle(1'b1, {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      1'b0, 58'h0);
        end
        dir_drain();

        // Additive PRBS7: seed 7'h01 with the first beat, then all-zero beats expose the keystream.
        add_m_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (i < 11) begin
                add_s_valid   = 1'b1;
                add_s_data    = (i == 0) ? 8'($urandom) : 8'h00;
                add_seed_load = (i == 0);
                add_seed_data = 7'h01;
                model_beat(M_ADD, K_ADD, {56'h0, add_s_data}, y);
                if (i == 0) hist[M_ADD] = 64'h01;
                add_q.push_back(y[7:0]);
            end else begin
                add_s_valid   = 1'b0;
                add_seed_load = 1'b0;
            end
            if (i > 0) begin
                check_eq("add_m_valid", 64'(add_m_valid), 64'd1);
                check_eq("add_data", 64'(add_m_data), 64'(add_q.pop_front()));
            end
            tick();
        end
        check_eq("add_count", 64'(add_beat_count), 64'd11);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
